// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: end-of-run detector for the multicycle CPU bench.
// Watches the fetch taps (pc/insn with a valid strobe) and ends the run on an exit
// instruction, a PC self-loop (spin) or a cycle watchdog. Counts RUN cycles and
// fetches, latches the final pc and result register, and derives pass/fail.
// Optional PC trace buffer is enabled by defining RUN_MONITOR_TRACE_EN.
module cpu_run_monitor #(
    parameter int                 PC_W           = 32,
    parameter int                 INSN_W         = 32,
    parameter int                 DATA_W         = 32,
    parameter int                 CNT_W          = 32,
    parameter logic [INSN_W-1:0]  EXIT_INSN      = 32'h0000000c,
    parameter int                 SPIN_COUNT     = 4,
    parameter int                 TIMEOUT_CYCLES = 1000,
    parameter logic [DATA_W-1:0]  EXPECT_RESULT  = '0,
    parameter int                 TRACE_DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  insn_valid,
    input  logic [PC_W-1:0]       pc,
    input  logic [INSN_W-1:0]     insn,
    input  logic [DATA_W-1:0]     result,
    output logic                  done,
    output logic [1:0]            status,
    output logic                  pass,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      insn_count,
    output logic [PC_W-1:0]       final_pc
`ifdef RUN_MONITOR_TRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [PC_W-1:0]       trace_pc
`endif
);

    // Spin run length never needs to exceed SPIN_COUNT: the run halts when it gets there.
    localparam int                RUN_W      = $clog2(SPIN_COUNT + 1);
    localparam logic [RUN_W-1:0]  SPIN_LIM   = RUN_W'(SPIN_COUNT);
    // Watchdog compare done at 64 bits so a limit beyond the counter range never aliases.
    localparam logic [63:0]       TIMEOUT_M1 = 64'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    localparam logic [1:0] STAT_RUN     = 2'd0;
    localparam logic [1:0] STAT_EXIT    = 2'd1;
    localparam logic [1:0] STAT_SPIN    = 2'd2;
    localparam logic [1:0] STAT_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              state_r;
    logic                done_r;
    logic [1:0]          status_r;
    logic [CNT_W-1:0]    cycle_count_r;
    logic [CNT_W-1:0]    insn_count_r;
    logic [PC_W-1:0]     final_pc_r;
    logic [DATA_W-1:0]   result_r;
    logic [PC_W-1:0]     prev_pc_r;
    logic [RUN_W-1:0]    run_r;

    logic [CNT_W-1:0]    cycle_inc_s;
    logic [CNT_W-1:0]    insn_inc_s;
    logic [RUN_W-1:0]    run_next_s;
    logic                exit_hit_s;
    logic                spin_hit_s;
    logic                timeout_hit_s;

    // Saturating increments, spin run-length update and halt-event decode.
    always_comb begin
        cycle_inc_s   = cycle_count_r;
        insn_inc_s    = insn_count_r;
        run_next_s    = RUN_W'(1'b1);
        if (cycle_count_r != CNT_MAX) begin
            cycle_inc_s = cycle_count_r + CNT_W'(1'b1);
        end else begin
            cycle_inc_s = cycle_count_r;
        end
        if (insn_count_r != CNT_MAX) begin
            insn_inc_s = insn_count_r + CNT_W'(1'b1);
        end else begin
            insn_inc_s = insn_count_r;
        end
        if (pc == prev_pc_r) begin
            if (run_r != SPIN_LIM) begin
                run_next_s = run_r + RUN_W'(1'b1);
            end else begin
                run_next_s = run_r;
            end
        end else begin
            run_next_s = RUN_W'(1'b1);
        end
        exit_hit_s    = insn_valid && (insn == EXIT_INSN);
        spin_hit_s    = insn_valid && (run_next_s == SPIN_LIM);
        timeout_hit_s = (64'(cycle_count_r) == TIMEOUT_M1);
    end

    // Run-control FSM: counts, spin tracking and halt capture, all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            done_r        <= 1'b0;
            status_r      <= STAT_RUN;
            cycle_count_r <= '0;
            insn_count_r  <= '0;
            final_pc_r    <= '0;
            result_r      <= '0;
            prev_pc_r     <= '0;
            run_r         <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (insn_valid) begin
                        state_r      <= ST_RUN;
                        insn_count_r <= CNT_W'(1'b1);
                        prev_pc_r    <= pc;
                        run_r        <= RUN_W'(1'b1);
                        if (exit_hit_s) begin
                            state_r    <= ST_HALTED;
                            done_r     <= 1'b1;
                            status_r   <= STAT_EXIT;
                            final_pc_r <= pc;
                            result_r   <= result;
                        end
                    end
                end
                ST_RUN: begin
                    cycle_count_r <= cycle_inc_s;
                    if (insn_valid) begin
                        insn_count_r <= insn_inc_s;
                        prev_pc_r    <= pc;
                        run_r        <= run_next_s;
                    end
                    if (exit_hit_s) begin
                        state_r    <= ST_HALTED;
                        done_r     <= 1'b1;
                        status_r   <= STAT_EXIT;
                        final_pc_r <= pc;
                        result_r   <= result;
                    end else if (spin_hit_s) begin
                        state_r    <= ST_HALTED;
                        done_r     <= 1'b1;
                        status_r   <= STAT_SPIN;
                        final_pc_r <= pc;
                        result_r   <= result;
                    end else if (timeout_hit_s) begin
                        state_r    <= ST_HALTED;
                        done_r     <= 1'b1;
                        status_r   <= STAT_TIMEOUT;
                        // Last fetched pc: this edge's fetch if present, else the previous one.
                        final_pc_r <= insn_valid ? pc : prev_pc_r;
                        result_r   <= result;
                    end
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign done        = done_r;
    assign status      = status_r;
    assign cycle_count = cycle_count_r;
    assign insn_count  = insn_count_r;
    assign final_pc    = final_pc_r;
    assign pass        = done_r
                         && ((status_r == STAT_EXIT) || (status_r == STAT_SPIN))
                         && (result_r == EXPECT_RESULT);

`ifdef RUN_MONITOR_TRACE_EN
    localparam int TR_W = $clog2(TRACE_DEPTH);

    logic [PC_W-1:0]        trace_mem_r [TRACE_DEPTH];
    logic [TRACE_DEPTH-1:0] trace_vld_r;
    logic [TR_W-1:0]        trace_wp_r;
    logic [TR_W-1:0]        trace_rd_s;
    logic                   trace_wr_s;

    assign trace_wr_s = insn_valid && ((state_r == ST_IDLE) || (state_r == ST_RUN));

    // Circular pc history: one entry per counted fetch, frozen once halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                trace_mem_r[i] <= '0;
            end
            trace_vld_r <= '0;
            trace_wp_r  <= '0;
        end else if (trace_wr_s) begin
            trace_mem_r[trace_wp_r] <= pc;
            trace_vld_r[trace_wp_r] <= 1'b1;
            trace_wp_r              <= trace_wp_r + TR_W'(1'b1);
        end
    end

    // Read relative to newest entry; never-written slots read as zero.
    always_comb begin
        trace_rd_s = trace_wp_r - TR_W'(1'b1) - trace_idx;
        if (trace_vld_r[trace_rd_s]) begin
            trace_pc = trace_mem_r[trace_rd_s];
        end else begin
            trace_pc = '0;
        end
    end
`endif

endmodule
